hc595_shift_ctrl: RTL and testbench

//  Serial back end of the 6-digit 7-segment display path. Consumes the parallel

---
 rtl/hc595_shift_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hc595_shift_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_shift_ctrl.sv
// Serial driver for two daisy-chained 74HC595s (segments + digit select).
// Optional periodic re-send enabled by defining HC595_REFRESH_EN.
module hc595_shift_ctrl #(
  parameter int SHCP_HALF      = 2,
  parameter int REFRESH_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_sta,
  input  logic [5:0] sel_out,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(SHCP_HALF) + 1;
  localparam logic [CW-1:0] HALF    = CW'(SHCP_HALF);
  localparam logic [CW-1:0] HALF_M1 = CW'(SHCP_HALF - 1);
  localparam logic [CW-1:0] BIT_END = CW'(2 * SHCP_HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [13:0]   shift_q, shift_d;
  logic [13:0]   last_q, last_d;
  logic          force_q, force_d;
  logic          force_clr;
  logic          force_set;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_n;
  logic          ds_q, ds_d;
  logic          shcp_q, shcp_d;
  logic          stcp_q, stcp_d;
  logic          oe_q, oe_d;
  logic          fd_q, fd_d;
  logic [13:0]   frame;

  assign frame = {data_sta, sel_out};
  assign cnt_n = cnt_q + 1'b1;

`ifdef HC595_REFRESH_EN
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REF_END = RW'(REFRESH_CYCLES - 1);

  logic [RW-1:0] ref_q, ref_d;

  // Free-running refresh timer; its wrap requests a re-send.
  always_comb begin
    ref_d     = ref_q + 1'b1;
    force_set = 1'b0;
    if (ref_q == REF_END) begin
      ref_d     = '0;
      force_set = 1'b1;
    end
  end

  // Refresh timer register.
  always_ff @(posedge clk) begin
    if (rst) ref_q <= '0;
    else     ref_q <= ref_d;
  end
`else
  assign force_set = 1'b0;
`endif

  // Next-state and output logic for the shift/latch sequencer.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    last_d    = last_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    ds_d      = ds_q;
    shcp_d    = shcp_q;
    stcp_d    = stcp_q;
    oe_d      = oe_q;
    fd_d      = 1'b0;
    force_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (force_q || (frame != last_q)) begin
          state_d   = SHIFT;
          shift_d   = frame;
          last_d    = frame;
          force_clr = 1'b1;
          bit_d     = 4'd13;
          cnt_d     = '0;
          ds_d      = frame[13];
          shcp_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == BIT_END) begin
          cnt_d  = '0;
          shcp_d = 1'b0;
          if (bit_q == 4'd0) begin
            state_d = LATCH;
            stcp_d  = 1'b1;
            fd_d    = (SHCP_HALF == 1);
          end else begin
            bit_d   = bit_q - 4'd1;
            shift_d = {shift_q[12:0], shift_q[13]};
            ds_d    = shift_q[12];
          end
        end else begin
          cnt_d  = cnt_n;
          shcp_d = (cnt_n >= HALF);
        end
      end
      LATCH: begin
        if (cnt_q == HALF_M1) begin
          state_d = IDLE;
          cnt_d   = '0;
          stcp_d  = 1'b0;
          oe_d    = 1'b0;
        end else begin
          cnt_d = cnt_n;
          fd_d  = (cnt_n == HALF_M1);
        end
      end
      default: begin
        state_d = IDLE;
        shcp_d  = 1'b0;
        stcp_d  = 1'b0;
      end
    endcase
    force_d = (force_q & ~force_clr) | force_set;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      last_q  <= '0;
      force_q <= 1'b1;
      bit_q   <= '0;
      cnt_q   <= '0;
      ds_q    <= 1'b0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      oe_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      force_q <= force_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      ds_q    <= ds_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
      oe_q    <= oe_d;
      fd_q    <= fd_d;
    end
  end

  assign ds         = ds_q;
  assign shcp       = shcp_q;
  assign stcp       = stcp_q;
  assign oe         = oe_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hc595_shift_ctrl.sv
// Directed bench for hc595_shift_ctrl: SHCP_HALF=2 main instance
// plus a SHCP_HALF=1 instance for the fast shift-clock case.
module tb_hc595_shift_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ds, shcp, stcp, oe, busy, frame_done;
  logic [7:0] data_sta;
  logic [5:0] sel_out;

  logic       rst_b, ds_b, shcp_b, stcp_b, oe_b, busy_b, fd_b;
  logic [7:0] data_b;
  logic [5:0] sel_b;

  int checks = 0;
  int errors = 0;

  hc595_shift_ctrl #(.SHCP_HALF(2), .REFRESH_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .data_sta(data_sta), .sel_out(sel_out),
    .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe), .busy(busy),
    .frame_done(frame_done)
  );

  hc595_shift_ctrl #(.SHCP_HALF(1), .REFRESH_CYCLES(200)) dut_b (
    .clk(clk), .rst(rst_b), .data_sta(data_b), .sel_out(sel_b),
    .ds(ds_b), .shcp(shcp_b), .stcp(stcp_b), .oe(oe_b), .busy(busy_b),
    .frame_done(fd_b)
  );

  // Monitor for the main instance.
  logic shcp_p = 1'b0;
  logic stcp_p = 1'b0;
  logic ds_p   = 1'b0;
  int   rises = 0, stcp_rises = 0, stcp_hi = 0, fd_cnt = 0, busy_hi = 0;
  logic bits[$];

  always @(negedge clk) begin
    if (shcp && !shcp_p) begin
      bits.push_back(ds);
      rises++;
    end
    if (shcp && shcp_p) begin
      checks++;
      if (ds !== ds_p) begin
        errors++;
        $display("FAIL ds_stable: ds=%b required %b while shcp high", ds, ds_p);
      end
    end
    if (stcp && !stcp_p) stcp_rises++;
    if (stcp) stcp_hi++;
    if (frame_done) fd_cnt++;
    if (busy) busy_hi++;
    shcp_p = shcp;
    stcp_p = stcp;
    ds_p   = ds;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_sta = 8'hC0;
    sel_out  = 6'b000001;
    repeat (3) step();
    checks++;
    if ({ds, shcp, stcp, oe, busy, frame_done} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000100",
               {ds, shcp, stcp, oe, busy, frame_done});
    end
  endtask

  task automatic test_first_frame();
    int n, b0, f0, s0, r0;
    logic [13:0] got;
    b0 = bits.size(); f0 = fd_cnt; s0 = stcp_hi; r0 = stcp_rises;
    rst = 1'b0;
    n = 0;
    while (fd_cnt == f0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n != 58) begin
      errors++;
      $display("FAIL first_latency: got %0d cycles required 58", n);
    end
    checks++;
    if (oe !== 1'b1) begin
      errors++;
      $display("FAIL oe_before_done: got %b required 1", oe);
    end
    got = '0;
    for (int i = 0; i < 14; i++) got[13-i] = bits[b0+i];
    checks++;
    if (got !== 14'b11000000_000001 || bits.size() - b0 != 14) begin
      errors++;
      $display("FAIL first_bits: got %b (%0d bits) required %b",
               got, bits.size() - b0, 14'b11000000_000001);
    end
    step();
    checks++;
    if ({oe, busy} !== 2'b00) begin
      errors++;
      $display("FAIL oe_after_done: oe,busy=%b required 00", {oe, busy});
    end
    checks++;
    if (stcp_hi - s0 != 2 || stcp_rises - r0 != 1 || fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL first_latch: stcp_hi=%0d pulses=%0d fd=%0d required 2 1 1",
               stcp_hi - s0, stcp_rises - r0, fd_cnt - f0);
    end
  endtask

  task automatic test_change_midframe();
    int n, b0, f0, s0;
    logic [13:0] g1, g2;
    b0 = bits.size(); f0 = fd_cnt; s0 = stcp_hi;
    sel_out = 6'b000010;
    n = 0;
    while (bits.size() < b0 + 3 && n < 100) begin
      step();
      n++;
    end
    data_sta = 8'hF9;
    checks++;
    if (busy !== 1'b1 || n >= 100) begin
      errors++;
      $display("FAIL mid_busy: busy=%b waited %0d required busy 1", busy, n);
    end
    n = 0;
    while (fd_cnt < f0 + 2 && n < 300) begin
      step();
      n++;
    end
    repeat (100) step();
    checks++;
    if (fd_cnt - f0 != 2 || stcp_hi - s0 != 4) begin
      errors++;
      $display("FAIL change_frames: fd=%0d stcp_hi=%0d required 2 4",
               fd_cnt - f0, stcp_hi - s0);
    end
    g1 = '0; g2 = '0;
    for (int i = 0; i < 14; i++) begin
      g1[13-i] = bits[b0+i];
      g2[13-i] = bits[b0+14+i];
    end
    checks++;
    if (g1 !== 14'b11000000_000010) begin
      errors++;
      $display("FAIL change_old: got %b required %b", g1, 14'b11000000_000010);
    end
    checks++;
    if (g2 !== 14'b11111001_000010 || bits.size() - b0 != 28) begin
      errors++;
      $display("FAIL change_new: got %b (%0d bits) required %b",
               g2, bits.size() - b0, 14'b11111001_000010);
    end
  endtask

  task automatic test_reset_midframe();
    int n, b0, f0;
    logic [13:0] got;
    b0 = bits.size();
    sel_out = 6'b000100;
    n = 0;
    while (bits.size() < b0 + 6 && n < 100) begin
      step();
      n++;
    end
    rst = 1'b1;
    f0 = fd_cnt;
    step();
    checks++;
    if ({ds, shcp, stcp, oe, busy, frame_done} !== 6'b000100) begin
      errors++;
      $display("FAIL midreset_outputs: got %b required 000100",
               {ds, shcp, stcp, oe, busy, frame_done});
    end
    rst = 1'b0;
    b0 = bits.size();
    n = 0;
    while (fd_cnt == f0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n != 58) begin
      errors++;
      $display("FAIL midreset_latency: got %0d cycles required 58", n);
    end
    got = '0;
    for (int i = 0; i < 14; i++) got[13-i] = bits[b0+i];
    checks++;
    if (got !== 14'b11111001_000100 || bits.size() - b0 != 14) begin
      errors++;
      $display("FAIL midreset_bits: got %b (%0d bits) required %b",
               got, bits.size() - b0, 14'b11111001_000100);
    end
    checks++;
    if (oe !== 1'b1) begin
      errors++;
      $display("FAIL midreset_oe_hold: got %b required 1", oe);
    end
    step();
    checks++;
    if (oe !== 1'b0) begin
      errors++;
      $display("FAIL midreset_oe_low: got %b required 0", oe);
    end
  endtask

  task automatic test_static();
    int r0, s0, b0;
    r0 = rises; s0 = stcp_rises; b0 = busy_hi;
    repeat (2000) step();
    checks++;
    if (rises != r0 || stcp_rises != s0 || busy_hi != b0) begin
      errors++;
      $display("FAIL static_idle: shcp=%0d stcp=%0d busy=%0d required 0 0 0",
               rises - r0, stcp_rises - s0, busy_hi - b0);
    end
  endtask

  task automatic test_half1();
    int n, fd_at, nr, st_hi, sh_hi;
    logic prev;
    logic [13:0] got;
    data_b = 8'hA5;
    sel_b  = 6'b100000;
    checks++;
    if ({shcp_b, stcp_b, oe_b, busy_b, fd_b} !== 5'b00100) begin
      errors++;
      $display("FAIL half1_reset: got %b required 00100",
               {shcp_b, stcp_b, oe_b, busy_b, fd_b});
    end
    rst_b = 1'b0;
    prev = shcp_b;
    fd_at = -1; nr = 0; st_hi = 0; sh_hi = 0; got = '0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (shcp_b && !prev) begin
        if (nr < 14) got[13-nr] = ds_b;
        nr++;
      end
      if (shcp_b) sh_hi++;
      if (stcp_b) st_hi++;
      if (fd_b && fd_at < 0) fd_at = c;
      prev = shcp_b;
    end
    checks++;
    if (fd_at != 29) begin
      errors++;
      $display("FAIL half1_latency: got %0d required 29", fd_at);
    end
    checks++;
    if (nr != 14 || sh_hi != 14 || st_hi != 1) begin
      errors++;
      $display("FAIL half1_clocks: rises=%0d shcp_hi=%0d stcp_hi=%0d required 14 14 1",
               nr, sh_hi, st_hi);
    end
    checks++;
    if (got !== 14'b10100101_100000) begin
      errors++;
      $display("FAIL half1_bits: got %b required %b", got, 14'b10100101_100000);
    end
    checks++;
    if ({oe_b, busy_b} !== 2'b00) begin
      errors++;
      $display("FAIL half1_end: oe,busy=%b required 00", {oe_b, busy_b});
    end
  endtask

  initial begin
    rst = 1'b1;
    rst_b = 1'b1;
    data_sta = 8'hC0;
    sel_out = 6'b000001;
    data_b = 8'hA5;
    sel_b = 6'b100000;
    test_reset();
    test_first_frame();
    test_static();
    test_change_midframe();
    test_reset_midframe();
    test_static();
    test_half1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
